// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the adder/subtractor family.
// Field widths, canonical special encodings and the sequencer state encoding.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int FP_W    = 1 + EXP_W + MAN_W;
    localparam int MAX_SHF = 25;
    localparam int CNT_W   = $clog2(MAX_SHF + 1);

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] FP_PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        PACK
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits one IEEE-754 single into sign, working exponent and 24-bit mantissa.
// Denormals get hidden bit 0 and working exponent 1 so they align like exponent-1 values.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [FP_W-1:0]  i_op,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [MAN_W:0]   o_man,
    output logic             o_is_nan,
    output logic             o_is_inf,
    output logic             o_is_zero
);

    logic [EXP_W-1:0] w_exp_f;
    logic [MAN_W-1:0] w_man_f;
    logic             w_hidden;

    assign w_exp_f   = i_op[FP_W-2:MAN_W];
    assign w_man_f   = i_op[MAN_W-1:0];
    assign w_hidden  = |w_exp_f;

    assign o_sign    = i_op[FP_W-1];
    assign o_exp     = w_hidden ? w_exp_f : EXP_W'(1);
    assign o_man     = {w_hidden, w_man_f};
    assign o_is_nan  = (&w_exp_f) && (|w_man_f);
    assign o_is_inf  = (&w_exp_f) && !(|w_man_f);
    assign o_is_zero = !w_hidden && !(|w_man_f);

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle truncating single-precision subtractor d = a - b with start/done handshake.
// Alignment and normalisation move one bit per cycle to keep the datapath a single adder.
module fp_sub_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [FP_W-1:0] d
);

    // Operand ordering: subtraction is addition of b with its sign flipped.
    logic [FP_W-1:0]  w_bn;
    logic             w_a_big;
    logic [FP_W-1:0]  w_big_op;
    logic [FP_W-1:0]  w_small_op;

    assign w_bn       = {~b[FP_W-1], b[FP_W-2:0]};
    assign w_a_big    = (a[FP_W-2:0] >= w_bn[FP_W-2:0]);
    assign w_big_op   = w_a_big ? a : w_bn;
    assign w_small_op = w_a_big ? w_bn : a;

    logic             w_big_sign,  w_small_sign;
    logic [EXP_W-1:0] w_big_exp,   w_small_exp;
    logic [MAN_W:0]   w_big_man,   w_small_man;
    logic             w_big_nan,   w_small_nan;
    logic             w_big_inf,   w_small_inf;
    logic             w_big_zero,  w_small_zero;

    fp_unpack u_unpack_big (
        .i_op      (w_big_op),
        .o_sign    (w_big_sign),
        .o_exp     (w_big_exp),
        .o_man     (w_big_man),
        .o_is_nan  (w_big_nan),
        .o_is_inf  (w_big_inf),
        .o_is_zero (w_big_zero)
    );

    fp_unpack u_unpack_small (
        .i_op      (w_small_op),
        .o_sign    (w_small_sign),
        .o_exp     (w_small_exp),
        .o_man     (w_small_man),
        .o_is_nan  (w_small_nan),
        .o_is_inf  (w_small_inf),
        .o_is_zero (w_small_zero)
    );

    // Magnitude ordering guarantees big exponent >= small exponent.
    logic [EXP_W-1:0] w_exp_diff;
    logic [CNT_W-1:0] w_cnt_init;

    assign w_exp_diff = w_big_exp - w_small_exp;
    assign w_cnt_init = (w_exp_diff >= EXP_W'(MAX_SHF)) ? CNT_W'(MAX_SHF)
                                                         : w_exp_diff[CNT_W-1:0];

    // Inf-inf is invalid when the raw signs of a and b match (true cancellation).
    logic            w_special;
    logic [FP_W-1:0] w_spec_val;

    always_comb begin
        w_special  = 1'b0;
        w_spec_val = '0;
        if (w_big_nan || w_small_nan || (w_big_inf && w_small_inf && (a[FP_W-1] == b[FP_W-1]))) begin
            w_special  = 1'b1;
            w_spec_val = FP_QNAN;
        end else if (w_big_inf || w_small_inf) begin
            w_special  = 1'b1;
            w_spec_val = FP_PINF | {w_big_sign, {(FP_W-1){1'b0}}};
        end else if (w_big_zero && w_small_zero) begin
            w_special  = 1'b1;
        end
    end

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [FP_W-1:0]  r_d;
    logic             r_sign;
    logic [EXP_W-1:0] r_exp;
    logic [MAN_W+1:0] r_man;
    logic [MAN_W:0]   r_small;
    logic             r_sub;
    logic [CNT_W-1:0] r_cnt;
    logic             r_special;
    logic [FP_W-1:0]  r_spec_val;

    logic [FP_W-1:0]  w_packed;

    always_comb begin
        w_packed = '0;
        if (r_special)
            w_packed = r_spec_val;
        else if (r_man == '0)
            w_packed = '0;
        else if (r_exp == '1)
            w_packed = FP_PINF | {r_sign, {(FP_W-1){1'b0}}};
        else if (!r_man[MAN_W])
            w_packed = {r_sign, {EXP_W{1'b0}}, r_man[MAN_W-1:0]};
        else
            w_packed = {r_sign, r_exp, r_man[MAN_W-1:0]};
    end

    // NOTE: only control state and the visible outputs are reset; datapath registers are
    // always loaded in IDLE before they are read, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_sign     <= w_big_sign;
                        r_exp      <= w_big_exp;
                        r_man      <= {1'b0, w_big_man};
                        r_small    <= w_small_man;
                        r_sub      <= w_big_sign ^ w_small_sign;
                        r_cnt      <= w_cnt_init;
                        r_special  <= w_special;
                        r_spec_val <= w_spec_val;
                        // Specials pass through NORM for one cycle, giving a two-edge bypass.
                        r_state    <= w_special ? NORM : ALIGN;
                    end
                end
                ALIGN: begin
                    if (r_cnt != '0) begin
                        r_small <= r_small >> 1;
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_man   <= r_sub ? (r_man - {1'b0, r_small}) : (r_man + {1'b0, r_small});
                    r_state <= NORM;
                end
                NORM: begin
                    if (r_special || (r_man == '0)) begin
                        r_state <= PACK;
                    end else if (r_man[MAN_W+1]) begin
                        r_man <= r_man >> 1;
                        r_exp <= r_exp + EXP_W'(1);
                    end else if (!r_man[MAN_W] && (r_exp > EXP_W'(1))) begin
                        r_man <= r_man << 1;
                        r_exp <= r_exp - EXP_W'(1);
                    end else begin
                        r_state <= PACK;
                    end
                end
                PACK: begin
                    r_d     <= w_packed;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed-vector bench for fp_sub_seq: results and start-to-done latency from a table,
// plus hand-written handshake, reset-abort and hold sequences.
module tb_fp_sub_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] d;

    int n_checks = 0;
    int n_fail   = 0;

    fp_sub_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        int          exp_lat;   // -1: latency not checked
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns result and edges from start to done.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] od, output int lat, output logic seen);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        seen  = 1'b0;
        od    = d;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat  = n;
                od   = d;
                seen = 1'b1;
                break;
            end
        end
    endtask

    logic [31:0] res;
    int          lat;
    logic        seen;
    int          n_done;
    logic [31:0] last_d;

    initial begin
        vecs[0]  = '{32'hC0B570A4, 32'hC1E70A3D, 32'h41B9AE14, 6};
        vecs[1]  = '{32'h3F800000, 32'h3F000000, 32'h3F000000, 6};
        vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 5};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 4};
        vecs[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2};
        vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 2};
        vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 2};
        vecs[9]  = '{32'h00000000, 32'h80000000, 32'h00000000, 2};
        vecs[10] = '{32'h3F000000, 32'h3F800000, 32'hBF000000, 6};
        vecs[11] = '{32'h00000003, 32'h00000001, 32'h00000002, 4};
        vecs[12] = '{32'h00800000, 32'h00400000, 32'h00400000, 4};
        vecs[13] = '{32'h00400000, 32'h80400000, 32'h00800000, 4};
        vecs[14] = '{32'h3F800000, 32'h33000000, 32'h3F800000, -1};
        vecs[15] = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 2};
        vecs[16] = '{32'h3F800000, 32'hFFC00001, 32'h7FC00000, 2};
        vecs[17] = '{32'h3F800000, 32'h33800000, 32'h3F800000, 28};

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_d", d, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].a, vecs[i].b, res, lat, seen);
            check($sformatf("vec%0d_done_seen", i), {31'd0, seen}, 32'd1);
            check($sformatf("vec%0d_d", i), res, vecs[i].exp_d);
            if (vecs[i].exp_lat >= 0)
                check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            @(posedge clk);
            #1;
        end

        // Result holds while idle.
        last_d = vecs[NVEC-1].exp_d;
        repeat (5) @(posedge clk);
        #1;
        check("hold_d", d, last_d);
        check("hold_done_low", {31'd0, done}, 32'd0);

        // start held high through the operation; operands change mid-flight.
        a      = 32'hC0B570A4;
        b      = 32'hC1E70A3D;
        start  = 1'b1;
        n_done = 0;
        lat    = 0;
        res    = '0;
        @(posedge clk);
        #1;
        check("hs_busy_after_start", {31'd0, busy}, 32'd1);
        a = 32'h3F800000;
        b = 32'h3F800000;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    lat = n;
                    res = d;
                    check("hs_busy_at_done", {31'd0, busy}, 32'd0);
                end
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("hs_done_count", n_done, 32'd1);
        check("hs_d", res, 32'h41B9AE14);
        check("hs_latency", lat, 32'd6);

        // Reset in the middle of a long alignment aborts cleanly.
        a     = 32'h3F800000;
        b     = 32'h33000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_d", d, 32'd0);
        n_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_late_done", n_done, 32'd0);

        // Still operational after the abort.
        do_op(32'h3F800000, 32'h3F000000, res, lat, seen);
        check("post_abort_d", res, 32'h3F000000);
        check("post_abort_latency", lat, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
